// File: rtl/transpose_pingpong_buffer_if.sv
// rtl/transpose_pingpong_buffer_if.sv - stream handshake bundle for the transpose ping-pong buffer
// Signals:
//   transpose_en  output order for the frame being written (sampled on its first pixel)
//   s_valid/s_data/s_ready             raster-order input pixel stream
//   m_valid/m_data/m_ready/m_eol/m_eof output pixel stream with line/frame markers
// Modports: master = stream source/sink around the buffer, slave = the buffer itself.
interface transpose_pingpong_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  transpose_en;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic                  m_eol;
  logic                  m_eof;

  modport master (
    output transpose_en, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_eol, m_eof
  );

  modport slave (
    input  transpose_en, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_eol, m_eof
  );
endinterface

// File: rtl/transpose_pingpong_buffer.sv
// rtl/transpose_pingpong_buffer.sv - double-buffered frame store with per-frame transpose/bypass readout
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; discards both banks
//   bus        slave side of the stream bundle (input pixels, output pixels, transpose_en)
//   bank_full  per-bank flag: bank holds a complete frame not yet fully read
module transpose_pingpong_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 110,
  parameter int IMAGE_HEIGHT = 103
) (
  input  logic                         clk,
  input  logic                         reset,
  transpose_pingpong_buffer_if.slave   bus,
  output logic [1:0]                   bank_full
);
  localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(IMAGE_WIDTH);
  localparam int RW    = $clog2(IMAGE_HEIGHT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] W_STEP    = AW'(IMAGE_WIDTH);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  bank_state_t state_q [2];
  bank_state_t state_d [2];
  logic [1:0]  mode_q;

  logic            wr_sel, rd_sel;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [RW-1:0]   rd_r;
  logic [CW-1:0]   rd_c;
  logic            wr_fire, wr_last, rd_fire, rd_last, rd_mode;
  logic [1:0]      wr_hit, rd_hit;

  logic                  m_valid_q, m_eol_q, m_eof_q;
  logic [DATA_WIDTH-1:0] m_data_q;

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  assign wr_fire = bus.s_valid && bus.s_ready;
  assign wr_last = (wr_addr == LAST_ADDR);
  // The output register is a one-entry skid: refill it whenever it is empty or being drained.
  assign rd_fire = bank_full[rd_sel] && (!m_valid_q || bus.m_ready);
  // Both orders end on the same (row, col) pair, so one terminal condition serves both.
  assign rd_last = (rd_r == LAST_ROW) && (rd_c == LAST_COL);
  assign rd_mode = mode_q[rd_sel];
  assign wr_hit  = {wr_fire && wr_sel, wr_fire && !wr_sel};
  assign rd_hit  = {rd_fire && rd_sel, rd_fire && !rd_sel};

  function automatic bank_state_t next_state(bank_state_t cur, logic whit, logic wlast,
                                             logic rhit, logic rlast);
    bank_state_t nxt = cur;
    unique case (cur)
      EMPTY:    if (whit) nxt = wlast ? FULL : FILLING;
      FILLING:  if (whit && wlast) nxt = FULL;
      FULL:     if (rhit) nxt = rlast ? EMPTY : DRAINING;
      DRAINING: if (rhit && rlast) nxt = EMPTY;
    endcase
    return nxt;
  endfunction

  // Bank state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Bank next-state
  always_comb begin
    state_d[0] = next_state(state_q[0], wr_hit[0], wr_last, rd_hit[0], rd_last);
    state_d[1] = next_state(state_q[1], wr_hit[1], wr_last, rd_hit[1], rd_last);
  end

  // Bank-derived outputs
  always_comb begin
    bus.s_ready  = (state_q[wr_sel] == EMPTY) || (state_q[wr_sel] == FILLING);
    bank_full[0] = (state_q[0] == FULL) || (state_q[0] == DRAINING);
    bank_full[1] = (state_q[1] == FULL) || (state_q[1] == DRAINING);
  end

  // Write side: raster address counter, bank toggle and per-bank mode capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel  <= 1'b0;
      wr_addr <= '0;
      mode_q  <= '0;
    end else if (wr_fire) begin
      if (wr_addr == '0) mode_q[wr_sel] <= bus.transpose_en;
      if (wr_last) begin
        wr_addr <= '0;
        wr_sel  <= ~wr_sel;
      end else begin
        wr_addr <= wr_addr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_sel) mem1[wr_addr] <= bus.s_data;
      else        mem0[wr_addr] <= bus.s_data;
    end
  end

  // Read side: (row, col) counters drive the markers; the address walks incrementally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sel    <= 1'b0;
      rd_addr   <= '0;
      rd_r      <= '0;
      rd_c      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_eol_q   <= 1'b0;
      m_eof_q   <= 1'b0;
    end else if (rd_fire) begin
      m_valid_q <= 1'b1;
      m_data_q  <= rd_sel ? mem1[rd_addr] : mem0[rd_addr];
      m_eol_q   <= rd_mode ? (rd_r == LAST_ROW) : (rd_c == LAST_COL);
      m_eof_q   <= rd_last;
      if (rd_last) begin
        rd_sel  <= ~rd_sel;
        rd_addr <= '0;
        rd_r    <= '0;
        rd_c    <= '0;
      end else if (rd_mode) begin
        // Column-major: step down a column by W, then jump to the top of the next column.
        if (rd_r == LAST_ROW) begin
          rd_r    <= '0;
          rd_c    <= rd_c + CW'(1);
          rd_addr <= AW'(rd_c) + AW'(1);
        end else begin
          rd_r    <= rd_r + RW'(1);
          rd_addr <= rd_addr + W_STEP;
        end
      end else begin
        rd_addr <= rd_addr + AW'(1);
        if (rd_c == LAST_COL) begin
          rd_c <= '0;
          rd_r <= rd_r + RW'(1);
        end else begin
          rd_c <= rd_c + CW'(1);
        end
      end
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_eol   = m_eol_q;
  assign bus.m_eof   = m_eof_q;
endmodule

// File: tb/tb_transpose_pingpong_buffer.sv
// tb/tb_transpose_pingpong_buffer.sv - directed self-checking bench for transpose_pingpong_buffer
module tb_transpose_pingpong_buffer;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct {
    logic [7:0] data;
    bit         first;
    bit         mode;
  } pix_t;

  typedef struct {
    logic [7:0] data;
    bit         eol;
    bit         eof;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] bank_full;

  transpose_pingpong_buffer_if #(.DATA_WIDTH(8)) bus ();

  transpose_pingpong_buffer #(
    .DATA_WIDTH   (8),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .bank_full (bank_full)
  );

  always #5 clk = ~clk;

  pix_t sendq [$];
  exp_t expq  [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc, n_acc, first_mv_cyc, last_wr_cyc, ready_mode, sready_low, mv_gap;
  bit   hold_chk, seen_mv;
  logic [9:0] held;
  int   t1_data [N] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(int base, bit mode);
    for (int k = 0; k < N; k++) begin
      pix_t p;
      p.data  = 8'(base + k);
      p.first = (k == 0);
      p.mode  = mode;
      sendq.push_back(p);
    end
  endtask

  // Reference ordering from the (row, col) definition of each readout mode.
  task automatic push_frame(int base, bit mode);
    send_frame(base, mode);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      int   idx;
      if (mode) begin
        idx   = (k % H) * W + k / H;
        e.eol = (k % H == H - 1);
      end else begin
        idx   = k;
        e.eol = (k % W == W - 1);
      end
      e.data = 8'(base + idx);
      e.eof  = (k == N - 1);
      expq.push_back(e);
    end
  endtask

  task automatic do_reset();
    bus.s_valid      = 1'b0;
    bus.s_data       = '0;
    bus.m_ready      = 1'b0;
    bus.transpose_en = 1'b0;
    reset            = 1'b1;
    sendq.delete();
    expq.delete();
    hold_chk   = 0;
    seen_mv    = 0;
    cyc        = 0;
    n_acc      = 0;
    mv_gap     = 0;
    sready_low = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_marks", {bus.m_eol, bus.m_eof}, 0);
    check("rst_bank_full", bank_full, 0);
  endtask

  // One clock: drive inputs, score both handshakes, then advance past the edge.
  task automatic cycle();
    exp_t e;
    if (sendq.size() > 0) begin
      bus.s_valid      = 1'b1;
      bus.s_data       = sendq[0].data;
      bus.transpose_en = sendq[0].first ? sendq[0].mode : 1'($urandom_range(0, 1));
    end else begin
      bus.s_valid      = 1'b0;
      bus.s_data       = '0;
      bus.transpose_en = 1'($urandom_range(0, 1));
    end
    case (ready_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (hold_chk)
      check("hold_stable", {bus.m_valid, bus.m_eof, bus.m_eol, bus.m_data}, {1'b1, held});
    if (bus.m_valid && bus.m_ready) begin
      check("out_expected", 32'(expq.size() > 0), 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("m_data", bus.m_data, e.data);
        check("m_eol", bus.m_eol, e.eol);
        check("m_eof", bus.m_eof, e.eof);
      end
    end
    if (bus.m_valid && !seen_mv) begin
      seen_mv      = 1;
      first_mv_cyc = cyc;
    end
    if (seen_mv && !bus.m_valid && expq.size() > 0) mv_gap++;
    if (bus.s_valid && !bus.s_ready) sready_low++;
    hold_chk = bus.m_valid && !bus.m_ready;
    held     = {bus.m_eof, bus.m_eol, bus.m_data};
    if (bus.s_valid && bus.s_ready) begin
      void'(sendq.pop_front());
      n_acc++;
      last_wr_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(int limit);
    int budget = limit;
    while ((sendq.size() > 0 || expq.size() > 0) && budget > 0) begin
      cycle();
      budget--;
    end
    check("drain_left", 32'(sendq.size() + expq.size()), 0);
  endtask

  initial begin
    // 1: transpose frame, hand-computed column-major order and latency
    do_reset();
    ready_mode = 1;
    send_frame(0, 1'b1);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      e.data = 8'(t1_data[k]);
      e.eol  = (t1_data[k] >= 8);
      e.eof  = (k == N - 1);
      expq.push_back(e);
    end
    drain(60);
    check("t1_latency", 32'(first_mv_cyc - last_wr_cyc), 2);
    check("t1_idle", {bank_full, bus.m_valid}, 0);

    // 2: bypass frame
    do_reset();
    ready_mode = 1;
    push_frame(0, 1'b0);
    drain(60);

    // 3: output stalled, both banks fill, then release
    do_reset();
    ready_mode = 0;
    push_frame(0, 1'b1);
    push_frame(32, 1'b0);
    push_frame(64, 1'b1);
    repeat (40) cycle();
    check("t3_accepted", 32'(n_acc), 24);
    check("t3_s_ready", bus.s_ready, 0);
    check("t3_bank_full", bank_full, 2'b11);
    ready_mode = 1;
    drain(150);
    check("t3_total", 32'(n_acc), 36);

    // 4: random backpressure, alternating modes
    do_reset();
    ready_mode = 2;
    for (int f = 0; f < 5; f++) push_frame(f * 20, 1'(f % 2 == 0));
    drain(800);

    // 5: reset while frame 1 drains and frame 2 is partly written
    do_reset();
    ready_mode = 1;
    push_frame(0, 1'b1);
    push_frame(100, 1'b0);
    for (int i = 0; i < 60 && n_acc < 19; i++) cycle();
    check("t5_acc", 32'(n_acc), 19);
    check("t5_pre", {bank_full, bus.m_valid}, 3'b011);
    do_reset();
    ready_mode = 1;
    push_frame(50, 1'b1);
    drain(60);

    // 6: back-to-back frames stream without bubbles
    do_reset();
    ready_mode = 1;
    for (int f = 0; f < 4; f++) push_frame(f * 16, 1'(f % 2));
    drain(200);
    check("t6_s_ready_drops", 32'(sready_low), 0);
    check("t6_m_valid_gaps", 32'(mv_gap), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
